// File: rtl/cpu_ctrl_pkg.sv
// Shared control encodings for the phase-2 sequencer and datapath benches.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'h0,
    S_T0   = 4'h1,
    S_T1   = 4'h2,
    S_T2   = 4'h3,
    S_T3   = 4'h4,
    S_T4   = 4'h5,
    S_T5   = 4'h6,
    S_T6   = 4'h7,
    S_T7   = 4'h8
  } state_t;

  typedef enum logic [1:0] {
    CLS_LD  = 2'd0,
    CLS_LDI = 2'd1,
    CLS_ST  = 2'd2
  } op_cls_t;

  localparam logic [4:0] OP_LD  = 5'h00;
  localparam logic [4:0] OP_LDI = 5'h01;
  localparam logic [4:0] OP_ST  = 5'h02;

  // T1 is always a memory access; T6 only for ld, T7 only for st.
  function automatic logic is_mem_state(input state_t s, input op_cls_t c);
    return (s == S_T1) || (s == S_T6 && c == CLS_LD) || (s == S_T7 && c == CLS_ST);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait-state timer: mem_done marks the last cycle of a memory state.
// MEM_READY_EN selects the mem_ready handshake instead of the fixed MEM_LATENCY count.
module mem_wait_timer #(
  parameter int MEM_LATENCY = 1
) (
  input  logic clock,
  input  logic clear,
  input  logic mem_state,
  input  logic mem_ready,
  output logic mem_done
);

`ifdef MEM_READY_EN
  logic unused_ok;
  assign unused_ok = &{clock, clear, 4'(MEM_LATENCY)};
  assign mem_done  = mem_state & mem_ready;
`else
  localparam logic [3:0] RELOAD = 4'(MEM_LATENCY - 1);
  logic [3:0] wait_cnt;
  logic       unused_ok;

  assign unused_ok = mem_ready;

  // Preloads while outside a memory state, so it is loaded on the entry cycle.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      wait_cnt <= 4'd0;
    end else if (!mem_state) begin
      wait_cnt <= RELOAD;
    end else if (wait_cnt != 4'd0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  assign mem_done = mem_state && (wait_cnt == 4'd0);
`endif

endmodule

// File: rtl/mem_op_sequencer.sv
// Hardwired Moore sequencer for fetch plus ld/ldi/st; strobes decode the state register.
// Latency at 1-cycle memory: ldi 6, ld/st 8, illegal 4; MEM_READY_EN waits on mem_ready.
module mem_op_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 5,
  parameter int MEM_LATENCY = 1
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                run,
  input  logic [OPCODE_W-1:0] ir_opcode,
  input  logic                mem_ready,
  output logic                PCout,
  output logic                IncPC,
  output logic                PCin,
  output logic                MARin,
  output logic                Read,
  output logic                Write,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Gra,
  output logic                Grb,
  output logic                Rin,
  output logic                Rout,
  output logic                BAout,
  output logic                RCout,
  output logic                Yin,
  output logic                ZLowIn,
  output logic                ZLowOut,
  output logic [3:0]          state_o,
  output logic                instr_done,
  output logic                illegal_op
);

  state_t  state_q, state_d;
  op_cls_t cls_q, cls_dec;
  logic    op_legal;
  logic    mem_state;
  logic    mem_done;
  state_t  after_instr;

  always_comb begin
    op_legal = 1'b1;
    cls_dec  = CLS_LD;
    if (ir_opcode == OPCODE_W'(OP_LD)) begin
      cls_dec = CLS_LD;
    end else if (ir_opcode == OPCODE_W'(OP_LDI)) begin
      cls_dec = CLS_LDI;
    end else if (ir_opcode == OPCODE_W'(OP_ST)) begin
      cls_dec = CLS_ST;
    end else begin
      op_legal = 1'b0;
    end
  end

  assign mem_state   = is_mem_state(state_q, cls_q);
  assign after_instr = run ? S_T0 : S_IDLE;

  mem_wait_timer #(.MEM_LATENCY(MEM_LATENCY)) u_wait (
    .clock     (clock),
    .clear     (clear),
    .mem_state (mem_state),
    .mem_ready (mem_ready),
    .mem_done  (mem_done)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_IDLE;
      cls_q   <= CLS_LD;
    end else begin
      state_q <= state_d;
      if (state_q == S_T3 && op_legal) begin
        cls_q <= cls_dec;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = run ? S_T0 : S_IDLE;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = mem_done ? S_T2 : S_T1;
      S_T2:   state_d = S_T3;
      S_T3:   state_d = op_legal ? S_T4 : after_instr;
      S_T4:   state_d = S_T5;
      S_T5:   state_d = (cls_q == CLS_LDI) ? after_instr : S_T6;
      S_T6:   state_d = (cls_q == CLS_LD && !mem_done) ? S_T6 : S_T7;
      S_T7:   state_d = (cls_q == CLS_ST && !mem_done) ? S_T7 : after_instr;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    PCout = 1'b0; IncPC = 1'b0; PCin = 1'b0; MARin = 1'b0; Read = 1'b0;
    Write = 1'b0; MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0; Gra = 1'b0;
    Grb = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0; RCout = 1'b0;
    Yin = 1'b0; ZLowIn = 1'b0; ZLowOut = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1; end
      S_T1: begin ZLowOut = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
        illegal_op = !op_legal;
      end
      S_T4: begin RCout = 1'b1; ZLowIn = 1'b1; end
      S_T5: begin
        ZLowOut = 1'b1;
        if (cls_q == CLS_LDI) begin
          Gra = 1'b1; Rin = 1'b1; instr_done = 1'b1;
        end else begin
          MARin = 1'b1;
        end
      end
      S_T6: begin
        MDRin = 1'b1;
        if (cls_q == CLS_ST) begin
          Gra = 1'b1; Rout = 1'b1;
        end else begin
          Read = 1'b1;
        end
      end
      S_T7: begin
        if (cls_q == CLS_ST) begin
          Write = 1'b1; instr_done = mem_done;
        end else begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; instr_done = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_mem_op_sequencer.sv
// Randomized instruction streams against a per-cycle expected-strobe model; two instances
// (MEM_LATENCY 1 and 3) share clock and clear. MEM_READY_EN switches the bench to handshake waits.
module tb_mem_op_sequencer;

  localparam logic [17:0] PCOUT  = 18'h20000, INCPC  = 18'h10000, PCIN  = 18'h08000;
  localparam logic [17:0] MARIN  = 18'h04000, READ   = 18'h02000, WRITE = 18'h01000;
  localparam logic [17:0] MDRIN  = 18'h00800, MDROUT = 18'h00400, IRIN  = 18'h00200;
  localparam logic [17:0] GRA    = 18'h00100, GRB    = 18'h00080, RIN   = 18'h00040;
  localparam logic [17:0] ROUT   = 18'h00020, BAOUT  = 18'h00010, RCOUT = 18'h00008;
  localparam logic [17:0] YIN    = 18'h00004, ZLIN   = 18'h00002, ZLOUT = 18'h00001;
  localparam logic [17:0] BUS    = PCOUT | ZLOUT | MDROUT | BAOUT | ROUT | RCOUT;

  typedef struct packed {
    logic [23:0] vec;
    logic        run;
    logic        rdy;
    logic [4:0]  op;
  } ent_t;

  logic        clock = 1'b0;
  logic        clear;
  logic        run_s [2];
  logic [4:0]  op_s  [2];
  logic        rdy_s [2];
  wire  [23:0] obs   [2];

  ent_t        q[$];
  logic [4:0]  cur_op;
  logic        cur_run;
  int          lat [2] = '{1, 3};
  int          errors = 0;
  int          checks = 0;
  bit          hit;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic s_pcout, s_incpc, s_pcin, s_marin, s_read, s_write, s_mdrin, s_mdrout, s_irin;
    logic s_gra, s_grb, s_rin, s_rout, s_baout, s_rcout, s_yin, s_zlin, s_zlout;
    logic [3:0] s_state;
    logic s_done, s_ill;

    mem_op_sequencer #(.OPCODE_W(5), .MEM_LATENCY(g == 0 ? 1 : 3)) dut (
      .clock(clock), .clear(clear), .run(run_s[g]), .ir_opcode(op_s[g]), .mem_ready(rdy_s[g]),
      .PCout(s_pcout), .IncPC(s_incpc), .PCin(s_pcin), .MARin(s_marin), .Read(s_read),
      .Write(s_write), .MDRin(s_mdrin), .MDRout(s_mdrout), .IRin(s_irin), .Gra(s_gra),
      .Grb(s_grb), .Rin(s_rin), .Rout(s_rout), .BAout(s_baout), .RCout(s_rcout),
      .Yin(s_yin), .ZLowIn(s_zlin), .ZLowOut(s_zlout),
      .state_o(s_state), .instr_done(s_done), .illegal_op(s_ill)
    );

    assign obs[g] = {s_state, s_done, s_ill, s_pcout, s_incpc, s_pcin, s_marin, s_read,
                     s_write, s_mdrin, s_mdrout, s_irin, s_gra, s_grb, s_rin, s_rout,
                     s_baout, s_rcout, s_yin, s_zlin, s_zlout};
  end

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic int mem_n(input int idx, input int override);
`ifdef MEM_READY_EN
    return (override > 0) ? override : int'($urandom_range(1, 4));
`else
    return lat[idx];
`endif
  endfunction

  task automatic add(input logic [3:0] st, input logic [17:0] s, input logic dn,
                     input logic il, input logic rdy);
    ent_t e;
    e.vec = {st, dn, il, s};
    e.run = cur_run;
    e.rdy = rdy;
    e.op  = cur_op;
    q.push_back(e);
  endtask

  // A memory access of n cycles; with the handshake, mem_ready rises only in the last one.
  task automatic add_mem(input logic [3:0] st, input logic [17:0] s, input logic last_done,
                         input int n);
    for (int i = 0; i < n; i++) begin
`ifdef MEM_READY_EN
      add(st, s, last_done && (i == n - 1), 1'b0, i == n - 1);
`else
      add(st, s, last_done && (i == n - 1), 1'b0, rb());
`endif
    end
  endtask

  task automatic build(input int idx, input logic [4:0] op, input logic r, input int t1n);
    cur_op  = op;
    cur_run = r;
    add(4'h1, PCOUT | MARIN | INCPC | ZLIN, 1'b0, 1'b0, rb());
    add_mem(4'h2, ZLOUT | PCIN | READ | MDRIN, 1'b0, mem_n(idx, t1n));
    add(4'h3, MDROUT | IRIN, 1'b0, 1'b0, rb());
    if (op > 5'h02) begin
      add(4'h4, GRB | BAOUT | YIN, 1'b0, 1'b1, rb());
    end else begin
      add(4'h4, GRB | BAOUT | YIN, 1'b0, 1'b0, rb());
      add(4'h5, RCOUT | ZLIN, 1'b0, 1'b0, rb());
      if (op == 5'h01) begin
        add(4'h6, ZLOUT | GRA | RIN, 1'b1, 1'b0, rb());
      end else begin
        add(4'h6, ZLOUT | MARIN, 1'b0, 1'b0, rb());
        if (op == 5'h00) begin
          add_mem(4'h7, READ | MDRIN, 1'b0, mem_n(idx, 0));
          add(4'h8, MDROUT | GRA | RIN, 1'b1, 1'b0, rb());
        end else begin
          add(4'h7, GRA | ROUT | MDRIN, 1'b0, 1'b0, rb());
          add_mem(4'h8, WRITE, 1'b1, mem_n(idx, 0));
        end
      end
    end
  endtask

  task automatic idle_entry(input logic r);
    cur_run = r;
    add(4'h0, 18'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rand_stream(input int idx, input int count);
    logic [4:0] op;
    logic       r;
    for (int i = 0; i < count; i++) begin
      case ($urandom_range(0, 3))
        0: op = 5'h00;
        1: op = 5'h01;
        2: op = 5'h02;
        default: op = 5'($urandom_range(3, 31));
      endcase
      r = ($urandom_range(0, 3) != 0);
      build(idx, op, r, 0);
      if (!r) idle_entry(1'b1);
    end
  endtask

  // One entry per clock: drive that cycle's inputs just after the edge, then compare.
  task automatic play(input int idx, input bit stop_at_t6, output bit t6_seen);
    ent_t e;
    logic [23:0] o;
    logic hz;
    t6_seen = 1'b0;
    while (q.size() > 0) begin
      e = q.pop_front();
      @(posedge clock);
      #1;
      run_s[idx] = e.run;
      rdy_s[idx] = e.rdy;
      op_s[idx]  = e.op;
      #1;
      o = obs[idx];
      check($sformatf("seq_i%0d_st%0h_op%0h", idx, e.vec[23:20], e.op), o, e.vec);
      hz = ($countones(o[17:0] & BUS) > 1) || (o[13] && o[12]);
      check($sformatf("hazard_i%0d", idx), 24'(hz), 24'h0);
      if (stop_at_t6 && e.vec[23:20] == 4'h7) begin
        t6_seen = 1'b1;
        q.delete();
      end
    end
  endtask

  initial begin
    clear    = 1'b0;
    run_s[0] = 1'b1; run_s[1] = 1'b0;
    rdy_s[0] = 1'b0; rdy_s[1] = 1'b0;
    op_s[0]  = 5'h00; op_s[1] = 5'h00;

    repeat (3) begin
      @(posedge clock);
      #1;
      check("reset_a", obs[0], 24'h0);
      check("reset_b", obs[1], 24'h0);
    end
    @(negedge clock);
    clear = 1'b1;

    // Instance 0: directed ops, illegal with and without run, then random traffic.
    build(0, 5'h00, 1'b1, 6);
    build(0, 5'h01, 1'b1, 0);
    build(0, 5'h02, 1'b1, 0);
    build(0, 5'h1F, 1'b0, 0);
    idle_entry(1'b1);
    build(0, 5'h1F, 1'b1, 0);
    build(0, 5'h00, 1'b0, 0);
    idle_entry(1'b1);
    rand_stream(0, 40);
    build(0, 5'h01, 1'b0, 0);
    idle_entry(1'b0);
    play(0, 1'b0, hit);

    // Instance 1: longer memory states.
    idle_entry(1'b1);
    build(1, 5'h02, 1'b1, 0);
    build(1, 5'h00, 1'b1, 0);
    build(1, 5'h01, 1'b1, 0);
    rand_stream(1, 15);
    build(1, 5'h01, 1'b0, 0);
    idle_entry(1'b0);
    play(1, 1'b0, hit);

    // Asynchronous clear in T6 of ld, then a fresh instruction from T0.
    idle_entry(1'b1);
    build(0, 5'h00, 1'b1, 0);
    play(0, 1'b1, hit);
    check("t6_reached", 24'(hit), 24'h1);
    clear = 1'b0;
    #1;
    check("clear_async", obs[0], 24'h0);
    repeat (2) begin
      @(posedge clock);
      #1;
      check("clear_hold", obs[0], 24'h0);
    end
    @(negedge clock);
    clear = 1'b1;
    build(0, 5'h02, 1'b0, 0);
    idle_entry(1'b0);
    play(0, 1'b0, hit);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
